// File: rtl/aucohl_tmr_pwm_mc_if.sv
// aucohl_tmr_pwm_mc_if: control, compare and PWM signal bundle for the multi-channel PWM timer.
interface aucohl_tmr_pwm_mc_if #(
  parameter int W = 32, NCH = 4, PRW = 16, DTW = 8
);
  logic en, start, oneshot, fault, fault_clr;
  logic [1:0] mode;
  logic [PRW-1:0] prescaler;
  logic [W-1:0] reload, tmr;
  logic [NCH*W-1:0] cmp;
  logic [NCH-1:0] cmp_wr, pwm_en, pwm_pol, match, pwm_out, pwm_n;
  logic [DTW-1:0] dt;
  logic running, period_flag, fault_sts;
  modport master (
    output en, start, mode, oneshot, prescaler, reload, cmp, cmp_wr, pwm_en, pwm_pol, fault, fault_clr, dt,
    input tmr, running, period_flag, match, fault_sts, pwm_out, pwm_n
  );
  modport slave (
    input en, start, mode, oneshot, prescaler, reload, cmp, cmp_wr, pwm_en, pwm_pol, fault, fault_clr, dt,
    output tmr, running, period_flag, match, fault_sts, pwm_out, pwm_n
  );
endinterface

// File: rtl/aucohl_tmr_pwm_mc.sv
// aucohl_tmr_pwm_mc: prescaled up/down/up-down timer driving NCH shadowed-compare PWM channels with fault latch.
// Define AUCOHL_TMR_PWM_DT_EN to compile in dead-time insertion on pwm_out/pwm_n rising edges.
module aucohl_tmr_pwm_mc #(
  parameter int W = 32, NCH = 4, PRW = 16, DTW = 8
) (
  input logic clk,
  input logic rst,
  aucohl_tmr_pwm_mc_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [W-1:0] tmr_q, tmr_d, rld_q, rld_d;
  logic [PRW-1:0] presc_q, presc_d;
  logic [1:0] mode_q, mode_d;
  logic dir_q, dir_d, fsts_q, fsts_d;
  logic [NCH*W-1:0] shd_q, shd_d, cmpa_q, cmpa_d;
  logic [NCH-1:0] raw, match, act_q, act_d, actn_q, actn_d;
  logic run, tick, at_top, at_bot, bot_end, pend;
  assign run = state_q == RUN;
  assign tick = run & bus.en & ~bus.start & (presc_q == '0);
  assign at_top = tmr_q >= rld_q;
  assign at_bot = tmr_q == '0;
  // up-down with reload 0 never leaves the bottom, so every tick closes a period
  assign bot_end = dir_q ? rld_q == '0 : at_bot;
  assign pend = tick & (mode_q == 2'b10 ? at_top : mode_q == 2'b01 ? at_bot : (mode_q == 2'b11) & bot_end);
  assign fsts_d = bus.fault | (fsts_q & ~bus.fault_clr);
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      shd_d[i*W +: W] = bus.cmp_wr[i] ? bus.cmp[i*W +: W] : shd_q[i*W +: W];
      raw[i] = tmr_q < cmpa_q[i*W +: W];
      match[i] = tick & (tmr_q == cmpa_q[i*W +: W]);
    end
  end
  assign act_d = bus.pwm_en & raw & {NCH{run & ~fsts_d}};
  assign actn_d = bus.pwm_en & ~(raw & {NCH{run}}) & {NCH{~fsts_d}};
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    rld_d = rld_q;
    presc_d = presc_q;
    mode_d = mode_q;
    dir_d = dir_q;
    cmpa_d = cmpa_q;
    if (!bus.en) state_d = IDLE;
    else if (bus.start) begin
      state_d = RUN;
      presc_d = '0;
      mode_d = bus.mode;
      dir_d = bus.mode != 2'b01;
      tmr_d = bus.mode == 2'b01 ? bus.reload : '0;
      rld_d = bus.reload;
      cmpa_d = shd_d;
    end else if (run) begin
      presc_d = presc_q == '0 ? bus.prescaler : presc_q - 1'b1;
      if (tick)
        case (mode_q)
          2'b10: tmr_d = at_top ? '0 : tmr_q + 1'b1;
          2'b01: tmr_d = at_bot ? bus.reload : tmr_q - 1'b1;
          2'b11: begin
            tmr_d = bot_end ? {{(W-1){1'b0}}, |bus.reload} : (dir_q & ~at_top) ? tmr_q + 1'b1 : tmr_q - 1'b1;
            dir_d = bot_end | (dir_q & ~at_top);
          end
          default: ;
        endcase
      if (pend) begin
        rld_d = bus.reload;
        cmpa_d = shd_d;
        if (bus.oneshot) begin
          state_d = IDLE;
          tmr_d = tmr_q;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      tmr_q <= '0;
      rld_q <= '0;
      presc_q <= '0;
      mode_q <= '0;
      dir_q <= 1'b0;
      fsts_q <= 1'b0;
      shd_q <= '0;
      cmpa_q <= '0;
      act_q <= '0;
      actn_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      rld_q <= rld_d;
      presc_q <= presc_d;
      mode_q <= mode_d;
      dir_q <= dir_d;
      fsts_q <= fsts_d;
      shd_q <= shd_d;
      cmpa_q <= cmpa_d;
      act_q <= act_d;
      actn_q <= actn_d;
    end
  assign bus.tmr = tmr_q;
  assign bus.running = run;
  assign bus.period_flag = pend;
  assign bus.match = match;
  assign bus.fault_sts = fsts_q;
`ifdef AUCOHL_TMR_PWM_DT_EN
  for (genvar c = 0; c < NCH; c++) begin : g_dt
    logic [DTW-1:0] ca_q, cn_q;
    // counts consecutive active cycles, saturating at dt; output goes active once dt cycles have elapsed
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        ca_q <= '0;
        cn_q <= '0;
      end else begin
        ca_q <= act_q[c] ? ca_q + DTW'(ca_q < bus.dt) : '0;
        cn_q <= actn_q[c] ? cn_q + DTW'(cn_q < bus.dt) : '0;
      end
    assign bus.pwm_out[c] = (act_q[c] & (ca_q >= bus.dt)) ^ bus.pwm_pol[c];
    assign bus.pwm_n[c] = (actn_q[c] & (cn_q >= bus.dt)) ^ bus.pwm_pol[c];
  end
`else
  logic unused_dt;
  assign unused_dt = ^bus.dt;
  assign bus.pwm_out = act_q ^ bus.pwm_pol;
  assign bus.pwm_n = actn_q ^ bus.pwm_pol;
`endif
endmodule

// File: tb/tb_aucohl_tmr_pwm_mc.sv
// tb_aucohl_tmr_pwm_mc: directed scenarios plus randomized traffic against a phase-based behavioural model.
module tb_aucohl_tmr_pwm_mc;
  localparam int W = 8, NCH = 2, PRW = 3, DTW = 3;
`ifdef AUCOHL_TMR_PWM_DT_EN
  localparam bit DT_ON = 1'b1;
`else
  localparam bit DT_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  aucohl_tmr_pwm_mc_if #(.W(W), .NCH(NCH), .PRW(PRW), .DTW(DTW)) bus ();
  aucohl_tmr_pwm_mc #(.W(W), .NCH(NCH), .PRW(PRW), .DTW(DTW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_run = 0, n_fail = 0;
  bit m_run, m_fs, e_tick, e_end;
  int m_ph, m_tmr, m_r, m_pc;
  logic [1:0] m_mode;
  int m_shd[NCH], m_cmp[NCH], m_la[NCH], m_ln[NCH];
  bit m_a[NCH], m_n[NCH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // timer value as a function of the tick position within the period
  function automatic int f_tmr(input int ph, input int r, input logic [1:0] md);
    if (md == 2'b01) return r - ph;
    if (md == 2'b11) return ph <= r ? ph : 2 * r - ph;
    return ph;
  endfunction

  task automatic model_reset();
    m_run = 0; m_fs = 0; m_ph = 0; m_tmr = 0; m_r = 0; m_pc = 0; m_mode = 2'b00;
    for (int i = 0; i < NCH; i++) begin
      m_shd[i] = 0; m_cmp[i] = 0; m_la[i] = 0; m_ln[i] = 0; m_a[i] = 0; m_n[i] = 0;
    end
  endtask

  task automatic model_comb();
    e_tick = m_run && bus.en && !bus.start && m_pc == 0;
    e_end = e_tick && m_mode != 2'b00 && m_ph == (m_mode == 2'b11 ? 2 * m_r : m_r);
  endtask

  task automatic model_next();
    int sh[NCH];
    bit fs, raw;
    fs = bus.fault || (m_fs && !bus.fault_clr);
    for (int i = 0; i < NCH; i++) begin
      sh[i] = bus.cmp_wr[i] ? int'(bus.cmp[i*W +: W]) : m_shd[i];
      raw = m_tmr < m_cmp[i];
      m_a[i] = bus.pwm_en[i] && m_run && !fs && raw;
      m_n[i] = bus.pwm_en[i] && !fs && !(m_run && raw);
      m_la[i] = m_a[i] ? m_la[i] + 1 : 0;
      m_ln[i] = m_n[i] ? m_ln[i] + 1 : 0;
    end
    if (!bus.en) m_run = 0;
    else if (bus.start) begin
      m_run = 1; m_pc = 0; m_mode = bus.mode; m_ph = 0; m_r = int'(bus.reload);
      m_cmp = sh;
      m_tmr = f_tmr(0, m_r, m_mode);
    end else if (m_run) begin
      m_pc = m_pc == 0 ? int'(bus.prescaler) : m_pc - 1;
      if (e_end) begin
        m_r = int'(bus.reload);
        m_cmp = sh;
        if (bus.oneshot) m_run = 0;
        else begin
          m_ph = (m_mode == 2'b11 && m_r != 0) ? 1 : 0;
          m_tmr = f_tmr(m_ph, m_r, m_mode);
        end
      end else if (e_tick && m_mode != 2'b00) begin
        m_ph++;
        m_tmr = f_tmr(m_ph, m_r, m_mode);
      end
    end
    m_shd = sh;
    m_fs = fs;
  endtask

  task automatic compare();
    logic [NCH-1:0] em, eo, en_;
    for (int i = 0; i < NCH; i++) begin
      em[i] = e_tick && m_tmr == m_cmp[i];
      eo[i] = bus.pwm_pol[i] ^ (m_a[i] && (!DT_ON || m_la[i] > int'(bus.dt)));
      en_[i] = bus.pwm_pol[i] ^ (m_n[i] && (!DT_ON || m_ln[i] > int'(bus.dt)));
    end
    check("tmr", bus.tmr, m_tmr);
    check("running", bus.running, m_run);
    check("period_flag", bus.period_flag, e_end);
    check("match", bus.match, em);
    check("fault_sts", bus.fault_sts, m_fs);
    check("pwm_out", bus.pwm_out, eo);
    check("pwm_n", bus.pwm_n, en_);
  endtask

  task automatic cyc();
    #1;
    if (rst) model_reset();
    model_comb();
    compare();
    @(posedge clk);
    if (!rst) model_next();
    @(negedge clk);
  endtask

  task automatic wr_cmp0(input int v);
    bus.cmp = {W'(0), W'(v)};
    bus.cmp_wr = 2'b01;
    cyc();
    bus.cmp_wr = 2'b00;
  endtask

  initial begin
    int cnt, cnt2, w;
    bus.en = 0; bus.start = 0; bus.mode = 2'b00; bus.oneshot = 0; bus.prescaler = '0;
    bus.reload = '0; bus.cmp = '0; bus.cmp_wr = '0; bus.pwm_en = '0; bus.pwm_pol = 2'b10;
    bus.fault = 0; bus.fault_clr = 0; bus.dt = DTW'($urandom_range(3, 0));
    model_reset();
    @(negedge clk);
    repeat (2) cyc();
    check("rst_pwm_out", bus.pwm_out, 2'b10);
    check("rst_pwm_n", bus.pwm_n, 2'b10);
    rst = 0;
    // up count, R=4
    bus.en = 1; bus.mode = 2'b10; bus.reload = 4; bus.pwm_en = 2'b11;
    bus.start = 1; cyc(); bus.start = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("up_tmr", bus.tmr, k % 5);
      check("up_flag", bus.period_flag, k % 5 == 4);
      cyc();
    end
    // up-down, R=3, cmp0=2: two matches per period
    wr_cmp0(2);
    bus.mode = 2'b11; bus.reload = 3; bus.start = 1; cyc(); bus.start = 0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      cnt += int'(bus.match[0]);
      cyc();
    end
    check("ud_match_cnt", cnt, 4);
    // down, R=5, oneshot, prescaler=1
    bus.mode = 2'b01; bus.reload = 5; bus.oneshot = 1; bus.prescaler = 1;
    bus.start = 1; cyc(); bus.start = 0;
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      cnt += int'(bus.period_flag);
      cyc();
    end
    check("os_flags", cnt, 1);
    check("os_running", bus.running, 0);
    check("os_tmr", bus.tmr, 0);
    bus.oneshot = 0; bus.prescaler = 0;
    // compare shadow update mid-period
    wr_cmp0(3);
    bus.mode = 2'b10; bus.reload = 9; bus.start = 1; cyc(); bus.start = 0;
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 30; k++) begin
      bus.cmp = {W'(0), W'(7)};
      bus.cmp_wr = {1'b0, k == 5};
      #1;
      if (k >= 1 && k <= 10) cnt += int'(bus.pwm_out[0]);
      if (k >= 11 && k <= 20) cnt2 += int'(bus.pwm_out[0]);
      cyc();
    end
    bus.cmp_wr = '0;
    check("duty_old", cnt, 3);
    check("duty_new", cnt2, 7);
    // fault while output high
    w = 0;
    while (bus.pwm_out[0] == 1'b0 && w < 30) begin
      cyc();
      w++;
    end
    check("fault_wait", w < 30, 1);
    bus.fault = 1; cyc(); bus.fault = 0;
    #1;
    check("fault_sts_set", bus.fault_sts, 1);
    check("fault_out", bus.pwm_out[0], 0);
    check("fault_n", bus.pwm_n[0], 0);
    repeat (3) cyc();
    bus.fault = 1; bus.fault_clr = 1; cyc(); bus.fault = 0; bus.fault_clr = 0;
    #1;
    check("fault_clr_ignored", bus.fault_sts, 1);
    bus.fault_clr = 1; cyc(); bus.fault_clr = 0;
    #1;
    check("fault_cleared", bus.fault_sts, 0);
    // dead-time: 50% duty, dt=3
    bus.pwm_en = 0; bus.dt = 3; cyc(); cyc(); bus.pwm_en = 2'b11;
    wr_cmp0(5);
    bus.reload = 9; bus.start = 1; cyc(); bus.start = 0;
    repeat (10) cyc();
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if ((bus.pwm_out[0] ^ bus.pwm_pol[0]) && (bus.pwm_n[0] ^ bus.pwm_pol[0])) cnt++;
      if (!(bus.pwm_out[0] ^ bus.pwm_pol[0]) && !(bus.pwm_n[0] ^ bus.pwm_pol[0])) cnt2++;
      cyc();
    end
    check("dt_overlap", cnt, 0);
    check("dt_gap", cnt2, DT_ON ? 24 : 0);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      bus.en = $urandom_range(99, 0) < 97;
      bus.start = $urandom_range(99, 0) < 4;
      bus.mode = 2'($urandom);
      bus.oneshot = $urandom_range(99, 0) < 20;
      bus.prescaler = PRW'($urandom_range(2, 0));
      bus.reload = W'($urandom_range(7, 0));
      bus.cmp = {W'($urandom_range(9, 0)), W'($urandom_range(9, 0))};
      bus.cmp_wr = ($urandom_range(99, 0) < 10) ? 2'($urandom) : 2'b00;
      if ($urandom_range(99, 0) < 3) bus.pwm_en = 2'($urandom);
      if ($urandom_range(99, 0) < 2) bus.pwm_pol = 2'($urandom);
      bus.fault = $urandom_range(99, 0) < 2;
      bus.fault_clr = $urandom_range(99, 0) < 6;
      rst = $urandom_range(999, 0) < 5;
      cyc();
    end
    rst = 0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/aucohl_tmr_pwm_mc.md
AUCOHL_TMR_PWM_MC -- requirements
Module: aucohl_tmr_pwm_mc

Interface
REQ-001 SHALL have parameter W, default 32, counter/compare width.
REQ-002 SHALL have parameter NCH, default 4, PWM channel count (1..8).
REQ-003 SHALL have parameter PRW, default 16, prescaler width.
REQ-004 SHALL have parameter DTW, default 8, dead-time width.
REQ-005 SHALL have ports: clk in 1, clock; rst in 1, reset, asynchronous, active-high.
REQ-006 SHALL have ports: en in 1, block enable; start in 1, start/restart pulse; mode in 2, 01 down, 10 up, 11 up-down, 00 hold; oneshot in 1.
REQ-007 SHALL have ports: prescaler in PRW; reload in W; cmp in NCH*W, channel i at bits [i*W +: W]; cmp_wr in NCH, shadow write strobes.
REQ-008 SHALL have ports: pwm_en in NCH; pwm_pol in NCH, 1 = active-low; fault in 1; fault_clr in 1; dt in DTW, dead-time in clk cycles.
REQ-009 SHALL have ports: tmr out W; running out 1; period_flag out 1; match out NCH; fault_sts out 1; pwm_out out NCH; pwm_n out NCH.

Function
REQ-010 Prescaler SHALL generate tick when its down-counter is 0, then reload prescaler; tick rate = clk/(prescaler+1); counter cleared on start.
REQ-011 States SHALL be IDLE and RUN; start (en=1) SHALL enter RUN from either state; en=0 SHALL force IDLE next cycle with tmr held.
REQ-012 On start, tmr SHALL load reload (mode 01) or 0 (modes 10/11); direction up except mode 01; active reload/compares SHALL load from shadows.
REQ-013 Up: tmr 0..R on ticks; on tick at R, tmr->0; period R+1 ticks.
REQ-014 Down: tmr R..0; on tick at 0, tmr->R.
REQ-015 Up-down: count up to R, then down to 0, direction flips at R and 0; period 2R ticks; R=0 holds tmr at 0.
REQ-016 Mode 00 SHALL hold tmr in RUN; no flags.
REQ-017 Period end (tick at R in up, at 0 in down/up-down) SHALL pulse period_flag 1 clk and transfer all shadow compares and reload to active registers.
REQ-018 oneshot=1: at period end SHALL enter IDLE holding the end value; running deasserts same edge.
REQ-019 cmp_wr[i] SHALL latch cmp slice i into shadow i; a write coinciding with period end SHALL be the value transferred.
REQ-020 match[i] SHALL pulse 1 clk on tick in RUN when tmr == active cmp[i].
REQ-021 Raw level[i] = (tmr < active cmp[i]); cmp=0 never active; cmp>R always active.
REQ-022 pwm_out[i] SHALL be registered, 1 clk after tmr: active level when pwm_en[i] & RUN & ~fault_sts & raw, else inactive; polarity applied by XOR with pwm_pol[i].
REQ-023 fault=1 SHALL set fault_sts next edge and force all outputs inactive that edge; fault_clr clears only while fault=0; fault wins if simultaneous.
REQ-024 pwm_n[i] SHALL be the complement of pwm_out[i] (same polarity) when enabled and not faulted, else inactive.

Reset
REQ-025 rst SHALL asynchronously set: IDLE, tmr=0, prescaler counter=0, shadows/actives=0, running=0, period_flag=0, match=0, fault_sts=0.
REQ-026 During reset pwm_out[i] and pwm_n[i] SHALL equal pwm_pol[i] (inactive).
REQ-027 Reset asserted mid-period SHALL abort RUN; no flag pulse on release.

Configuration
REQ-028 Macro AUCOHL_TMR_PWM_DT_EN SHALL compile dead-time insertion in.
REQ-029 With macro: each rising (inactive->active) transition of pwm_out[i] and pwm_n[i] SHALL be delayed dt clk cycles; falling immediate; both never active together; dt=0 equals no delay.
REQ-030 Without macro: dt SHALL be ignored and pwm_n per REQ-024 with no delay.

Verification
REQ-031 Up, R=4, prescaler=0, start -> tmr 0,1,2,3,4,0; period_flag every 5 clk at tmr=4.
REQ-032 Up-down, R=3, cmp0=2, pol=0 -> tmr 0,1,2,3,2,1,0; pwm_out[0] high while tmr<2, 1 clk later; match[0] twice per period.
REQ-033 Down, R=5, oneshot=1, prescaler=1 -> tmr 5..0 on every 2nd clk; IDLE at 0; running=0; single period_flag.
REQ-034 Up, R=9, cmp0=3; write cmp0=7 mid-period -> duty stays 3 until period end, 7 from next period.
REQ-035 fault pulse 1 clk while pwm high -> outputs inactive, fault_sts=1 until fault_clr; fault_clr with fault=1 ignored.
REQ-036 Macro on, dt=3, 50% duty -> 3-clk gap with both pwm_out[0] and pwm_n[0] inactive at every transition.
